// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and helpers for the FIFO-fed word serializer.
package fifo_word_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } ser_state_e;

  localparam int WORDS_W = 16;

  // Counter width that stays legal (>=1) for a count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO read side, transmit control and serial status bundled for the serializer.
interface fifo_word_serializer_if #(
  parameter int DATA_W = 16
);
  import fifo_word_serializer_pkg::*;

  logic                tx_en;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_dout;
  logic                fifo_rd_en;
  logic                ser_out;
  logic                busy;
  logic                frame_done;
  logic [WORDS_W-1:0]  words_sent;

  modport master (
    input  tx_en, fifo_empty, fifo_dout,
    output fifo_rd_en, ser_out, busy, frame_done, words_sent
  );

  modport slave (
    output tx_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, ser_out, busy, frame_done, words_sent
  );

endinterface

// File: rtl/fifo_word_serializer_bit_timer.sv
// Down-counter that marks the last clock of every serial bit period with a tick.
module fifo_word_serializer_bit_timer
  import fifo_word_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW     = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a sync FIFO and sends each as start(0), data bits, stop(1).
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  fifo_word_serializer_if.master  bus
);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 1");
  end

  localparam int               IDX_W    = cnt_width(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  ser_state_e          state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORDS_W-1:0]  words_q, words_d;
  logic                ser_q, ser_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tick, start_ok, timer_en, timer_restart;

  assign start_ok      = bus.tx_en && !bus.fifo_empty;
  assign timer_en      = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
  assign timer_restart = (state_q == ST_LOAD);

  fifo_word_serializer_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rstn      (rstn),
    .restart_i (timer_restart),
    .en_i      (timer_en),
    .tick_o    (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && (idx_q == LAST_IDX)) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The shift register always presents the bit currently on the line at its output end.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    words_d = words_q;
    case (state_q)
      ST_LOAD: begin
        shift_d = bus.fifo_dout;
        idx_d   = '0;
      end
      ST_DATA: begin
        if (tick && (idx_q != LAST_IDX)) begin
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
          idx_d   = idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) words_d = words_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up with it.
  always_comb begin
    rd_en_d = (state_q == ST_IDLE) && start_ok;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
    case (state_d)
      ST_START: ser_d = 1'b0;
      ST_DATA:  ser_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_W-1];
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      idx_q   <= '0;
      words_q <= '0;
      ser_q   <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      ser_q   <= ser_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.ser_out    = ser_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.words_sent = words_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: behavioural FIFO feeds the serializer, scoreboard checks every line cycle.
module tb_fifo_word_serializer;

  localparam int DATA_W      = 16;
  localparam int CPB         = 4;
  localparam int LINE_CYCLES = (DATA_W + 2) * CPB;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_word_serializer_if #(.DATA_W(DATA_W)) bus ();

  fifo_word_serializer #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB),
    .LSB_FIRST    (1)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int underflows = 0;
  int last_wait;
  int rd_seen;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] fifo_mem[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [15:0]       exp_words;

  // Behavioural sync FIFO: data valid the cycle after rd_en is sampled; not reset by rstn.
  always @(posedge clk) begin
    if (bus.fifo_rd_en === 1'b1) begin
      if (fifo_mem.size() == 0) underflows <= underflows + 1;
      else bus.fifo_dout <= fifo_mem.pop_front();
    end
    if (wr_en === 1'b1) fifo_mem.push_back(wr_data);
    bus.fifo_empty <= (fifo_mem.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    wr_data = w;
    wr_en   = 1'b1;
    exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input int drop_bit, input int rst_bit);
    logic [DATA_W-1:0] w;
    logic              exp_bit;
    int                n;
    n = 0;
    while (bus.fifo_rd_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    check("rd_en_seen", bus.fifo_rd_en, 1'b1);
    if (bus.fifo_rd_en !== 1'b1 || exp_q.size() == 0) return;
    w = exp_q.pop_front();
    @(negedge clk);
    check("rd_en_one_cycle", bus.fifo_rd_en, 1'b0);
    check("load_line_high", bus.ser_out, 1'b1);
    for (int k = 0; k < LINE_CYCLES; k++) begin
      @(negedge clk);
      if (k < CPB) exp_bit = 1'b0;
      else if (k < LINE_CYCLES - CPB) exp_bit = w[(k - CPB) / CPB];
      else exp_bit = 1'b1;
      check($sformatf("line_cycle%0d", k), bus.ser_out, exp_bit);
      check("busy_in_frame", bus.busy, 1'b1);
      check("no_early_done", bus.frame_done, 1'b0);
      if (drop_bit >= 0 && k == CPB + drop_bit * CPB) bus.tx_en = 1'b0;
      if (rst_bit >= 0 && k == CPB + rst_bit * CPB + 1) begin
        rstn = 1'b0;
        #1;
        check("abort_line_high", bus.ser_out, 1'b1);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_rd_en", bus.fifo_rd_en, 1'b0);
        check("abort_words", bus.words_sent, 16'h0000);
        exp_words = 16'h0000;
        @(negedge clk);
        check("abort_no_done_a", bus.frame_done, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        check("abort_no_done_b", bus.frame_done, 1'b0);
        return;
      end
    end
    @(negedge clk);
    exp_words = exp_words + 16'd1;
    check("frame_done", bus.frame_done, 1'b1);
    check("busy_idle", bus.busy, 1'b0);
    check("words_sent", bus.words_sent, exp_words);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn       = 1'b0;
    bus.tx_en  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = '0;
    exp_words  = 16'h0000;

    // Reset state, then an idle empty FIFO must never be popped.
    #20;
    check("rst_ser_out", bus.ser_out, 1'b1);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.frame_done, 1'b0);
    check("rst_words", bus.words_sent, 16'h0000);
    #30;
    rstn      = 1'b1;
    bus.tx_en = 1'b1;
    rd_seen   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en === 1'b1) rd_seen++;
    end
    check("empty_no_rd_en", rd_seen, 0);
    check("empty_busy", bus.busy, 1'b0);

    // Single word.
    push_word(16'hA5C3);
    run_frame(-1, -1);
    check("single_latency", last_wait, 1);

    // Burst of four, back to back.
    bus.tx_en = 1'b0;
    push_word(16'h1234);
    push_word(16'h8001);
    push_word(16'h0000);
    push_word(16'h7E5A);
    bus.tx_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, -1);
      check($sformatf("burst_gap%0d", f), last_wait, 1);
    end
    check("burst_fifo_empty", bus.fifo_empty, 1'b1);

    // tx_en dropped mid-frame.
    bus.tx_en = 1'b0;
    push_word(16'h3C3C);
    push_word(16'h0F0F);
    push_word(16'hF00D);
    bus.tx_en = 1'b1;
    run_frame(5, -1);
    rd_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en === 1'b1) rd_seen++;
    end
    check("hold_no_rd_en", rd_seen, 0);
    check("hold_busy", bus.busy, 1'b0);
    bus.tx_en = 1'b1;
    run_frame(-1, -1);
    check("resume_latency", last_wait, 1);
    run_frame(-1, -1);

    // Reset mid-DATA aborts the frame; the next word goes out cleanly.
    bus.tx_en = 1'b0;
    push_word(16'hBEEF);
    push_word(16'h1357);
    bus.tx_en = 1'b1;
    run_frame(-1, 6);
    run_frame(-1, -1);
    check("post_abort_latency", last_wait, 1);

    // Counter wrap.
    force dut.words_q = 16'hFFFF;
    @(negedge clk);
    release dut.words_q;
    @(negedge clk);
    check("wrap_preload", bus.words_sent, 16'hFFFF);
    exp_words = 16'hFFFF;
    push_word(16'hC0DE);
    run_frame(-1, -1);
    check("wrap_zero", bus.words_sent, 16'h0000);

    check("final_fifo_empty", bus.fifo_empty, 1'b1);
    check("final_scoreboard_empty", exp_q.size(), 0);
    check("no_underflow", underflows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
